// File: rtl/encryption_functions.sv
// encryption_functions: AES-128 GF(2^8) helpers, S-box, key expansion and shared types
package encryption_functions;
  typedef logic [127:0] aes_block_t;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic logic [7:0] mul2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] mul3(input logic [7:0] x);
    return mul2(x) ^ x;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047-8*int'(x) -: 8];
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  // One step of the AES-128 schedule: word 3 is rotated, substituted and salted with rcon
  function automatic aes_block_t expand_key(input aes_block_t rk, input logic [7:0] rcon);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({rk[23:0], rk[31:24]}) ^ {rcon, 24'h0};
    n0 = rk[127:96] ^ t;
    n1 = rk[95:64] ^ n0;
    n2 = rk[63:32] ^ n1;
    n3 = rk[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction
endpackage

// File: rtl/aes_round_comb.sv
// aes_round_comb: one AES round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey)
module aes_round_comb
  import encryption_functions::*;
(
  input  aes_block_t state,
  input  aes_block_t round_key,
  input  logic       final_round,
  output aes_block_t next_state
);
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  always_comb begin
    next_state = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sbox(state[127-8*(4*((c+r)%4)+r) -: 8]);
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = mul2(sr[4*c]) ^ mul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ mul2(sr[4*c+1]) ^ mul3(sr[4*c+2]) ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ mul2(sr[4*c+2]) ^ mul3(sr[4*c+3]);
      mc[4*c+3] = mul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ mul2(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++)
      next_state[127-8*i -: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
  end
endmodule

// File: rtl/aes128_round_scheduler.sv
// aes128_round_scheduler: iterative AES-128 encryptor, one round per clock with on-the-fly key expansion
module aes128_round_scheduler
  import encryption_functions::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_plaintext,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_ciphertext,
  output logic         busy,
  output logic [3:0]   round_idx
);
  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes128_round_scheduler supports only NUM_ROUNDS=10");
  end
  state_e     fsm, fsm_n;
  aes_block_t state_reg, rk_reg, next_rk, round_out;
  logic [7:0] rcon;
  logic       last;
  assign next_rk = expand_key(rk_reg, rcon);
  assign last = round_idx == 4'(NUM_ROUNDS);
  aes_round_comb u_round (
    .state      (state_reg),
    .round_key  (next_rk),
    .final_round(last),
    .next_state (round_out)
  );
  always_comb begin
    fsm_n = fsm == IDLE  ? (in_valid ? ROUND : IDLE) :
            fsm == ROUND ? (last ? DONE : ROUND) :
                           (out_ready ? IDLE : DONE);
    in_ready = fsm == IDLE;
    busy = fsm != IDLE;
  end
  assign out_ciphertext = state_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      state_reg <= '0;
      rk_reg    <= '0;
      rcon      <= RCON_INIT;
      round_idx <= '0;
      out_valid <= 1'b0;
    end else begin
      fsm <= fsm_n;
      if (fsm == IDLE && in_valid) begin
        state_reg <= in_plaintext ^ in_key;
        rk_reg    <= in_key;
        rcon      <= RCON_INIT;
        round_idx <= 4'd1;
      end else if (fsm == ROUND) begin
        state_reg <= round_out;
        rk_reg    <= next_rk;
        rcon      <= mul2(rcon);
        round_idx <= last ? round_idx : round_idx + 4'd1;
        out_valid <= last;
      end else if (fsm == DONE && out_ready) begin
        out_valid <= 1'b0;
        round_idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_aes128_round_scheduler.sv
// tb_aes128_round_scheduler: directed FIPS-197 vectors plus handshake, reset and backpressure scenarios
module tb_aes128_round_scheduler;
  logic clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_plaintext, in_key, out_ciphertext;
  logic [3:0] round_idx;
  int checks = 0, failures = 0;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes128_round_scheduler #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_plaintext(in_plaintext), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_ciphertext(out_ciphertext), .busy(busy),
    .round_idx(round_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && !in_ready; n++) tick();
  endtask

  task automatic send_block(input logic [127:0] pt, input logic [127:0] key,
                            output int lat, output logic [127:0] ct);
    wait_idle();
    in_plaintext = pt;
    in_key = key;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    ct = out_ciphertext;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 5;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (round_idx !== 4'd0) begin failures++; $display("FAIL reset_round_idx got=%0d want=0", round_idx); end
    if (out_ciphertext !== 128'h0) begin failures++; $display("FAIL reset_ct got=%h want=0", out_ciphertext); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_ready_noeffect got=%b want=0", out_valid); end
  endtask

  task automatic test_fips_b();
    int lat;
    logic [127:0] ct;
    out_ready = 1'b1;
    send_block(PB, KB, lat, ct);
    checks += 3;
    if (lat !== 10) begin failures++; $display("FAIL fipsb_latency got=%0d want=10", lat); end
    if (ct !== CB) begin failures++; $display("FAIL fipsb_ct got=%h want=%h", ct, CB); end
    if (round_idx !== 4'd10) begin failures++; $display("FAIL fipsb_done_round got=%0d want=10", round_idx); end
    tick();
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL fipsb_valid_one_cycle got=%b want=0", out_valid); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL fipsb_back_idle got=%b want=1", in_ready); end
  endtask

  task automatic test_fips_c();
    int n = 0;
    logic [7:0] r8 = 8'h00, r9 = 8'h00;
    wait_idle();
    in_plaintext = PC;
    in_key = KC;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 40) begin
      if (round_idx == 4'd8) r8 = dut.rcon;
      if (round_idx == 4'd9) r9 = dut.rcon;
      tick();
      n++;
    end
    checks += 4;
    if (out_ciphertext !== CC) begin failures++; $display("FAIL fipsc_ct got=%h want=%h", out_ciphertext, CC); end
    if (n !== 10) begin failures++; $display("FAIL fipsc_latency got=%0d want=10", n); end
    if (r8 !== 8'h80) begin failures++; $display("FAIL fipsc_rcon8 got=%h want=80", r8); end
    if (r9 !== 8'h1b) begin failures++; $display("FAIL fipsc_rcon9 got=%h want=1b", r9); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [127:0] ct;
    out_ready = 1'b0;
    send_block(PB, KB, lat, ct);
    checks += 2;
    if (lat !== 10) begin failures++; $display("FAIL bp_latency got=%0d want=10", lat); end
    if (ct !== CB) begin failures++; $display("FAIL bp_ct got=%h want=%h", ct, CB); end
    in_plaintext = PC;
    in_key = KC;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b want=1", i, out_valid); end
      if (out_ciphertext !== CB) begin failures++; $display("FAIL bp_hold_ct cyc=%0d got=%h want=%h", i, out_ciphertext, CB); end
      if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
    end
    out_ready = 1'b1;
    tick();
    checks += 2;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_idle got=%b want=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b want=0", out_valid); end
    tick();
    in_valid = 1'b0;
    checks += 2;
    if (busy !== 1'b1) begin failures++; $display("FAIL bp_next_accept_busy got=%b want=1", busy); end
    if (round_idx !== 4'd1) begin failures++; $display("FAIL bp_next_accept_round got=%0d want=1", round_idx); end
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (out_ciphertext !== CC) begin failures++; $display("FAIL bp_next_ct got=%h want=%h", out_ciphertext, CC); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic [127:0] ct1 = '0;
    logic seen = 1'b0;
    wait_idle();
    out_ready = 1'b1;
    in_plaintext = PB;
    in_key = KB;
    in_valid = 1'b1;
    tick();
    in_plaintext = PC;
    in_key = KC;
    while (n < 40 && !(seen && round_idx == 4'd1)) begin
      if (out_valid) begin
        ct1 = out_ciphertext;
        seen = 1'b1;
      end
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks += 2;
    if (n !== 12) begin failures++; $display("FAIL b2b_interval got=%0d want=12", n); end
    if (ct1 !== CB) begin failures++; $display("FAIL b2b_ct1 got=%h want=%h", ct1, CB); end
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checks += 2;
    if (n !== 10) begin failures++; $display("FAIL b2b_latency2 got=%0d want=10", n); end
    if (out_ciphertext !== CC) begin failures++; $display("FAIL b2b_ct2 got=%h want=%h", out_ciphertext, CC); end
    tick();
  endtask

  task automatic test_reset_mid();
    int n = 0, lat;
    logic [127:0] ct;
    wait_idle();
    in_plaintext = PC;
    in_key = KC;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (round_idx != 4'd5 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (round_idx !== 4'd5) begin failures++; $display("FAIL rmid_reach5 got=%0d want=5", round_idx); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", busy); end
    if (round_idx !== 4'd0) begin failures++; $display("FAIL rmid_round got=%0d want=0", round_idx); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
    if (out_ciphertext !== 128'h0) begin failures++; $display("FAIL rmid_ct_cleared got=%h want=0", out_ciphertext); end
    send_block(PB, KB, lat, ct);
    checks += 2;
    if (lat !== 10) begin failures++; $display("FAIL rmid_latency got=%0d want=10", lat); end
    if (ct !== CB) begin failures++; $display("FAIL rmid_ct got=%h want=%h", ct, CB); end
    tick();
  endtask

  task automatic test_input_ignore();
    int n = 0;
    wait_idle();
    in_plaintext = PC;
    in_key = KC;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    while (!out_valid && n < 40) begin
      in_plaintext = {$urandom, $urandom, $urandom, $urandom};
      in_key = {$urandom, $urandom, $urandom, $urandom};
      tick();
      n++;
    end
    checks += 2;
    if (n !== 10) begin failures++; $display("FAIL ignore_latency got=%0d want=10", n); end
    if (out_ciphertext !== CC) begin failures++; $display("FAIL ignore_ct got=%h want=%h", out_ciphertext, CC); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_plaintext = '0;
    in_key = '0;
    test_reset();
    test_fips_b();
    test_fips_c();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_input_ignore();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
